// File: rtl/lb_updown_counter_p.sv
// Loadable up/down counter slice with programmable modulus, optional saturation,
// synchronous clear, cascadable carry and a registered one-cycle wrap flag.
module lb_updown_counter_p #(
  parameter int     WIDTH       = 8,
  parameter longint MODULUS     = 0,
  parameter int     SATURATE    = 0,
  parameter longint RESET_VALUE = 0
) (
  input  logic             CK,
  input  logic             GSRN,
  input  logic             SP,
  input  logic             SCLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             CI,
  input  logic             CON,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             WRAP
);

  localparam longint FULL_L = (longint'(1) << WIDTH);
  localparam longint MAX_L  = (MODULUS == 0) ? (FULL_L - 1) : (MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX   = MAX_L[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("lb_updown_counter_p: WIDTH must be 1..32");
  end
  if (MODULUS < 0 || MODULUS > FULL_L) begin : g_bad_modulus
    $error("lb_updown_counter_p: MODULUS exceeds 2**WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE > MAX_L) begin : g_bad_reset
    $error("lb_updown_counter_p: RESET_VALUE exceeds MAX");
  end

  // Load data above the modulus range is clamped to the terminal value.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  // One count step modulo MAX+1, or sticking at the end when saturating.
  function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] v,
                                                  input logic up);
    if (up) begin
      if (v == MAX) return (SATURATE != 0) ? MAX : '0;
      return v + 1'b1;
    end
    if (v == '0) return (SATURATE != 0) ? '0 : MAX;
    return v - 1'b1;
  endfunction

  logic terminal;

  assign terminal = CON ? (Q == MAX) : (Q == '0);
  // Carry ignores SP/SCLR/LOAD so a chain of slices can share one enable.
  assign CO = CI & terminal;

  always_ff @(posedge CK or negedge GSRN) begin
    if (!GSRN) begin
      Q    <= RST_Q;
      WRAP <= 1'b0;
    end else begin
      WRAP <= SP & ~SCLR & ~LOAD & CO;
      if (SP) begin
        if (SCLR)      Q <= '0;
        else if (LOAD) Q <= clamp_load(D);
        else if (CI)   Q <= count_step(Q, CON);
      end
    end
  end

endmodule
